// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two wide operands one chunk per cycle through a shared external adder
module wide_add_sequencer #(
    parameter int ADDER_WIDTH = 32,
    parameter int NUM_CHUNKS  = 4,
    parameter int CNT_WIDTH   = $clog2(NUM_CHUNKS)
) (
    input  logic                              iClk,
    input  logic                              iRstn,
    input  logic                              iValid,
    output logic                              oReady,
    input  logic [ADDER_WIDTH*NUM_CHUNKS-1:0] iA,
    input  logic [ADDER_WIDTH*NUM_CHUNKS-1:0] iB,
    input  logic                              iCarry,
    output logic [ADDER_WIDTH-1:0]            oChunkA,
    output logic [ADDER_WIDTH-1:0]            oChunkB,
    output logic                              oChunkCarry,
    input  logic [ADDER_WIDTH-1:0]            iChunkSum,
    input  logic                              iChunkCarry,
    output logic                              oValid,
    input  logic                              iReady,
    output logic [ADDER_WIDTH*NUM_CHUNKS-1:0] oSum,
    output logic                              oCarry
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT                             state;
    logic [CNT_WIDTH-1:0]              count;
    logic                              carryReg;
    logic [ADDER_WIDTH*NUM_CHUNKS-1:0] opA;
    logic [ADDER_WIDTH*NUM_CHUNKS-1:0] opB;
    logic [ADDER_WIDTH*NUM_CHUNKS-1:0] sumReg;

    wire lastChunk = count == CNT_WIDTH'(NUM_CHUNKS - 1);
    wire accept    = iValid && oReady;

    assign oReady      = (state == IDLE) || (state == DONE && iReady);
    assign oValid      = state == DONE;
    assign oSum        = sumReg;
    assign oCarry      = carryReg;
    assign oChunkA     = (state == RUN) ? opA[count*ADDER_WIDTH +: ADDER_WIDTH] : '0;
    assign oChunkB     = (state == RUN) ? opB[count*ADDER_WIDTH +: ADDER_WIDTH] : '0;
    assign oChunkCarry = (state == RUN) ? carryReg : 1'b0;

    // Sequence capture, per-chunk accumulation with carry chaining, and result handoff
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state    <= IDLE;
            count    <= '0;
            carryReg <= 1'b0;
            opA      <= '0;
            opB      <= '0;
            sumReg   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        opA      <= iA;
                        opB      <= iB;
                        carryReg <= iCarry;
                        count    <= '0;
                        state    <= RUN;
                    end else if (state == DONE && iReady) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sumReg[count*ADDER_WIDTH +: ADDER_WIDTH] <= iChunkSum;
                    carryReg <= iChunkCarry;
                    count    <= lastChunk ? '0 : count + CNT_WIDTH'(1);
                    state    <= lastChunk ? DONE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed and randomised checks of the chunked adder sequencer
module tb_wide_add_sequencer;
    localparam int AW = 8;
    localparam int NC = 4;
    localparam int TW = AW * NC;

    logic          iClk = 1'b0;
    logic          iRstn = 1'b0;
    logic          iValid = 1'b0;
    logic          iCarry = 1'b0;
    logic          iReady = 1'b0;
    logic [TW-1:0] iA = '0;
    logic [TW-1:0] iB = '0;
    logic          oReady, oChunkCarry, oValid, oCarry, iChunkCarry;
    logic [TW-1:0] oSum;
    logic [AW-1:0] oChunkA, oChunkB, iChunkSum;

    int nVec = 0;
    int nErr = 0;
    logic [AW-1:0] chunkSeq [NC];
    logic [NC-1:0] carrySeq;

    wide_add_sequencer #(.ADDER_WIDTH(AW), .NUM_CHUNKS(NC)) dut (
        .iClk(iClk), .iRstn(iRstn), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .iCarry(iCarry),
        .oChunkA(oChunkA), .oChunkB(oChunkB), .oChunkCarry(oChunkCarry),
        .iChunkSum(iChunkSum), .iChunkCarry(iChunkCarry),
        .oValid(oValid), .iReady(iReady), .oSum(oSum), .oCarry(oCarry)
    );

    // Reference chunk adder the sequencer drives
    assign {iChunkCarry, iChunkSum} = {1'b0, oChunkA} + {1'b0, oChunkB} + {8'b0, oChunkCarry};

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic launch(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c);
        iA = a;
        iB = b;
        iCarry = c;
        iValid = 1'b1;
        #1;
        checkVal("ready_at_launch", oReady, 1);
        tick();
        iValid = 1'b0;
        for (int k = 0; k < NC; k++) begin
            chunkSeq[k] = oChunkA;
            carrySeq[k] = oChunkCarry;
            checkVal("busy_valid", oValid, 0);
            checkVal("busy_ready", oReady, 0);
            tick();
        end
        checkVal("latency_valid", oValid, 1);
    endtask

    task automatic release_result();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checkVal("idle_valid", oValid, 0);
        checkVal("idle_ready", oReady, 1);
    endtask

    initial begin
        logic [32:0] expQ [$];
        logic [TW-1:0] ra, rb;
        logic rc;
        logic pend;
        int sent, nGot;

        tick();
        checkVal("rst_valid", oValid, 0);
        checkVal("rst_ready", oReady, 1);
        checkVal("rst_sum", {oCarry, oSum}, 0);
        checkVal("rst_chunk", {oChunkA, oChunkB, oChunkCarry}, 0);
        iRstn = 1'b1;
        tick();

        launch(32'h00000001, 32'h00000002, 1'b0);
        checkVal("t1_sum", {oCarry, oSum}, 33'h0_00000003);
        release_result();

        launch(32'hFFFFFFFF, 32'h00000000, 1'b1);
        checkVal("t2_ripple", carrySeq, 4'hF);
        checkVal("t2_sum", {oCarry, oSum}, 33'h1_00000000);
        release_result();

        launch(32'h80FF00FF, 32'h80010001, 1'b0);
        checkVal("t3_chunkA", {chunkSeq[3], chunkSeq[2], chunkSeq[1], chunkSeq[0]}, 32'h80FF00FF);
        checkVal("t3_sum", {oCarry, oSum}, 33'h1_01000100);

        for (int k = 0; k < 5; k++) begin
            iReady = 1'b0;
            iValid = k[0];
            iA = $urandom;
            #1;
            checkVal("stall_sum", {oCarry, oSum}, 33'h1_01000100);
            checkVal("stall_valid", oValid, 1);
            checkVal("stall_ready", oReady, 0);
            tick();
        end
        iReady = 1'b1;
        launch(32'h12345678, 32'h11111111, 1'b1);
        iReady = 1'b0;
        checkVal("b2b_sum", {oCarry, oSum}, 33'h0_2345678A);
        release_result();

        iA = 32'hAABBCCDD;
        iB = 32'h11223344;
        iCarry = 1'b1;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        tick();
        iRstn = 1'b0;
        #1;
        checkVal("mid_rst_valid", oValid, 0);
        checkVal("mid_rst_ready", oReady, 1);
        checkVal("mid_rst_sum", {oCarry, oSum}, 0);
        checkVal("mid_rst_chunk", {oChunkA, oChunkB, oChunkCarry}, 0);
        tick();
        tick();
        iRstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkVal("post_rst_valid", oValid, 0);
            tick();
        end
        launch(32'h0000FFFF, 32'h00000001, 1'b0);
        checkVal("post_rst_sum", {oCarry, oSum}, 33'h0_00010000);
        release_result();

        sent = 0;
        nGot = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 20000 && nGot < 1000; cyc++) begin
            iReady = $urandom_range(0, 3) != 0;
            if (!pend && sent < 1000) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                iA = ra;
                iB = rb;
                iCarry = rc;
                iValid = 1'b1;
                pend = 1'b1;
            end
            #1;
            if (oValid && iReady) begin
                if (expQ.size() == 0) checkVal("rnd_extra", oValid, 0);
                else begin
                    checkVal("rnd_sum", {oCarry, oSum}, expQ.pop_front());
                    nGot++;
                end
            end
            if (iValid && oReady) begin
                expQ.push_back({1'b0, ra} + {1'b0, rb} + 33'(rc));
                sent++;
                pend = 1'b0;
            end
            tick();
            if (!pend) iValid = 1'b0;
        end
        checkVal("rnd_count", nGot, 1000);
        checkVal("rnd_leftover", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
